// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Watches the PLL lock indicator and drives the PLL reset. Once lock has
//   been stable for LOCK_FILTER cycles, the memory, core and video domain
//   resets are released one after another, STAGE_GAP cycles apart. The block
//   runs on the free-running reference clock, so it keeps working while the
//   PLL is unlocked. If the PLL fails to lock within RELOCK_TIMEOUT cycles,
//   it is pulsed back into reset. Any loss of lock after the first release
//   re-asserts every downstream reset as a group.
//
// Ports:
//   refclk          in   free-running reference clock, rising edge
//   rst             in   asynchronous active-high block reset
//   pll_locked      in   PLL lock flag, asynchronous to refclk
//   pll_rst         out  active-high PLL reset
//   mem_rst         out  memory domain reset request (released first)
//   core_rst        out  core domain reset request (released second)
//   video_rst       out  video domain reset request (released last)
//   ready           out  high only while every domain is released
//   lock_loss_count out  saturating count of lock losses seen in RUN
//   retry_count     out  saturating count of relock timeouts
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 1024,
  parameter int STAGE_GAP      = 256,
  parameter int RELOCK_TIMEOUT = 1048576,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             mem_rst,
  output logic             core_rst,
  output logic             video_rst,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] retry_count
);

  // The single timer must hold the largest terminal count of any state.
  localparam int MAX_AB  = (RELOCK_TIMEOUT > LOCK_FILTER) ? RELOCK_TIMEOUT : LOCK_FILTER;
  localparam int MAX_CD  = (STAGE_GAP > PLL_RST_CYCLES) ? STAGE_GAP : PLL_RST_CYCLES;
  localparam int T_MAX   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  // The timer reads 0 on the edge that enters a state. A state whose
  // terminal count is N therefore leaves on the N-th edge after entry,
  // which is the edge on which the timer already reads N-1.
  localparam logic [TIMER_W-1:0] PLL_LAST    = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FILTER_LAST = TIMER_W'(LOCK_FILTER - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST    = TIMER_W'(STAGE_GAP - 1);
  localparam logic [TIMER_W-1:0] RELOCK_LAST = TIMER_W'(RELOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_FILTER,
    S_REL_MEM,
    S_REL_CORE,
    S_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]     loss_cnt_q, loss_cnt_d;
  logic [CNT_W-1:0]     retry_cnt_q, retry_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 lk;

  logic pll_rst_q, pll_rst_d;
  logic mem_rst_q, mem_rst_d;
  logic core_rst_q, core_rst_d;
  logic video_rst_q, video_rst_d;
  logic ready_q, ready_d;

  // ---------------------------------------------------------------------
  // Lock synchroniser: bit 0 samples the asynchronous input, the last bit
  // is the only lock view used by the sequencer.
  // ---------------------------------------------------------------------
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lk = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLL_RESET;
      timer_q     <= '0;
      loss_cnt_q  <= '0;
      retry_cnt_q <= '0;
      pll_rst_q   <= 1'b1;
      mem_rst_q   <= 1'b1;
      core_rst_q  <= 1'b1;
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      loss_cnt_q  <= loss_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      pll_rst_q   <= pll_rst_d;
      mem_rst_q   <= mem_rst_d;
      core_rst_q  <= core_rst_d;
      video_rst_q <= video_rst_d;
      ready_q     <= ready_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TIMER_W'(1);
    loss_cnt_d  = loss_cnt_q;
    retry_cnt_d = retry_cnt_q;

    case (state_q)
      S_PLL_RESET: begin
        if (timer_q == PLL_LAST) begin
          state_d = S_WAIT_LOCK;
        end
      end

      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lk) begin
          state_d = S_FILTER;
        end else if (timer_q == RELOCK_LAST) begin
          state_d = S_PLL_RESET;
          if (retry_cnt_q != '1) begin
            retry_cnt_d = retry_cnt_q + CNT_W'(1);
          end
        end
      end

      S_FILTER: begin
        // A drop takes priority over a coincident filter completion.
        if (!lk) begin
          state_d = S_WAIT_LOCK;
        end else if (timer_q == FILTER_LAST) begin
          state_d = S_REL_MEM;
        end
      end

      S_REL_MEM: begin
        if (!lk) begin
          state_d = S_WAIT_LOCK;
        end else if (timer_q == GAP_LAST) begin
          state_d = S_REL_CORE;
        end
      end

      S_REL_CORE: begin
        if (!lk) begin
          state_d = S_WAIT_LOCK;
        end else if (timer_q == GAP_LAST) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // The timer has no use here; hold it rather than let it wrap.
        timer_d = timer_q;
        if (!lk) begin
          state_d = S_WAIT_LOCK;
          if (loss_cnt_q != '1) begin
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_PLL_RESET;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs follow the next state so that they change on the same edge as
  // the transition. Leaving REL_MEM, REL_CORE or RUN always lands in
  // WAIT_LOCK, so all domain resets re-assert together.
  // ---------------------------------------------------------------------
  always_comb begin
    pll_rst_d   = (state_d == S_PLL_RESET);
    mem_rst_d   = !((state_d == S_REL_MEM) || (state_d == S_REL_CORE) || (state_d == S_RUN));
    core_rst_d  = !((state_d == S_REL_CORE) || (state_d == S_RUN));
    video_rst_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
  end

  assign pll_rst         = pll_rst_q;
  assign mem_rst         = mem_rst_q;
  assign core_rst        = core_rst_q;
  assign video_rst       = video_rst_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_cnt_q;
  assign retry_count     = retry_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer. Expected output snapshots are
// queued with the refclk edge number at which they must hold; a monitor on
// the falling edge pops and compares them. Edge numbers are counted from the
// edge immediately preceding each rst release.
// Flag vector order: {pll_rst, mem_rst, core_rst, video_rst, ready}.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int CNT_W = 8;

  logic             refclk;
  logic             rst;
  logic             pll_locked;
  logic             pll_rst;
  logic             mem_rst;
  logic             core_rst;
  logic             video_rst;
  logic             ready;
  logic [CNT_W-1:0] lock_loss_count;
  logic [CNT_W-1:0] retry_count;

  pll_reset_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_FILTER   (8),
    .STAGE_GAP     (4),
    .RELOCK_TIMEOUT(64),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .mem_rst        (mem_rst),
    .core_rst       (core_rst),
    .video_rst      (video_rst),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .retry_count    (retry_count)
  );

  typedef struct {
    string      tag;
    int         at;
    logic [4:0] flags;
    logic [7:0] ll;
    logic [7:0] rc;
  } exp_t;

  // Handy flag patterns
  localparam logic [4:0] F_RESET = 5'b11110;  // PLL in reset, all domains held
  localparam logic [4:0] F_HOLD  = 5'b01110;  // PLL running, all domains held
  localparam logic [4:0] F_MEM   = 5'b00110;  // memory released
  localparam logic [4:0] F_CORE  = 5'b00010;  // memory + core released
  localparam logic [4:0] F_RUN   = 5'b00001;  // everything released

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  always @(posedge refclk) cyc++;

  task automatic push(input string tag, input int at, input logic [4:0] f,
                      input logic [7:0] ll, input logic [7:0] rc);
    exp_t e;
    e.tag   = tag;
    e.at    = at;
    e.flags = f;
    e.ll    = ll;
    e.rc    = rc;
    exp_q.push_back(e);
  endtask

  // Returns 1 ns after the posedge that makes cyc equal n.
  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Scoreboard monitor: compare on the falling edge.
  always @(negedge refclk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      exp_t       e;
      logic [4:0] obs;
      e   = exp_q.pop_front();
      obs = {pll_rst, mem_rst, core_rst, video_rst, ready};
      checks++;
      assert (e.at == cyc) else begin
        failures++;
        $error("FAIL %s stale: checked at edge %0d, required edge %0d", e.tag, cyc, e.at);
      end
      checks++;
      assert (obs === e.flags) else begin
        failures++;
        $error("FAIL %s flags @%0d: got %b want %b", e.tag, cyc, obs, e.flags);
      end
      checks++;
      assert (lock_loss_count === e.ll) else begin
        failures++;
        $error("FAIL %s lock_loss_count @%0d: got %0d want %0d", e.tag, cyc, lock_loss_count, e.ll);
      end
      checks++;
      assert (retry_count === e.rc) else begin
        failures++;
        $error("FAIL %s retry_count @%0d: got %0d want %0d", e.tag, cyc, retry_count, e.rc);
      end
      $display("txn %-14s edge=%0d flags=%b ll=%0d rc=%0d", e.tag, cyc, obs, lock_loss_count, retry_count);
    end
  end

  initial begin
    int t0, t1, L, R, S, W, k252, k253;
    logic [4:0] obs;

    rst        = 1'b1;
    pll_locked = 1'b0;

    // Reset state while rst is held
    push("reset_hold", 3, F_RESET, 8'd0, 8'd0);
    wait_to(4);
    rst = 1'b0;
    t0  = cyc;

    // 1. Cold start
    push("cold_pll_hi", t0 + 3, F_RESET, 8'd0, 8'd0);
    push("cold_pll_lo", t0 + 4, F_HOLD, 8'd0, 8'd0);
    wait_to(t0 + 9);
    pll_locked = 1'b1;
    push("cold_filter", t0 + 19, F_HOLD, 8'd0, 8'd0);
    push("cold_mem", t0 + 20, F_MEM, 8'd0, 8'd0);
    push("cold_mem_gap", t0 + 23, F_MEM, 8'd0, 8'd0);
    push("cold_core", t0 + 24, F_CORE, 8'd0, 8'd0);
    push("cold_core_gap", t0 + 27, F_CORE, 8'd0, 8'd0);
    push("cold_run", t0 + 28, F_RUN, 8'd0, 8'd0);

    // 4. Lock loss in RUN, then relock with identical offsets
    wait_to(t0 + 30);
    pll_locked = 1'b0;
    push("loss_pending", t0 + 32, F_RUN, 8'd0, 8'd0);
    push("loss_all_rst", t0 + 33, F_HOLD, 8'd1, 8'd0);
    push("loss_wait", t0 + 36, F_HOLD, 8'd1, 8'd0);
    wait_to(t0 + 40);
    L = cyc;
    pll_locked = 1'b1;
    push("relock_filter", L + 10, F_HOLD, 8'd1, 8'd0);
    push("relock_mem", L + 11, F_MEM, 8'd1, 8'd0);
    push("relock_mem_gap", L + 14, F_MEM, 8'd1, 8'd0);
    push("relock_core", L + 15, F_CORE, 8'd1, 8'd0);
    push("relock_core_gp", L + 18, F_CORE, 8'd1, 8'd0);
    push("relock_run", L + 19, F_RUN, 8'd1, 8'd0);

    // 6. Asynchronous rst mid-RUN, off the clock edge
    wait_to(L + 22);
    #2;
    rst        = 1'b1;
    pll_locked = 1'b0;
    #1;
    obs = {pll_rst, mem_rst, core_rst, video_rst, ready};
    checks++;
    assert (obs === F_RESET) else begin
      failures++;
      $error("FAIL async_rst flags: got %b want %b", obs, F_RESET);
    end
    checks++;
    assert (lock_loss_count === 8'd0 && retry_count === 8'd0) else begin
      failures++;
      $error("FAIL async_rst counts: got ll=%0d rc=%0d want 0 0", lock_loss_count, retry_count);
    end
    $display("txn async_rst      flags=%b ll=%0d rc=%0d", obs, lock_loss_count, retry_count);
    push("arst_hold", L + 24, F_RESET, 8'd0, 8'd0);
    wait_to(L + 25);
    rst = 1'b0;
    t1  = cyc;
    push("cold2_pll_hi", t1 + 3, F_RESET, 8'd0, 8'd0);
    push("cold2_pll_lo", t1 + 4, F_HOLD, 8'd0, 8'd0);
    wait_to(t1 + 9);
    pll_locked = 1'b1;
    push("cold2_filter", t1 + 19, F_HOLD, 8'd0, 8'd0);
    push("cold2_mem", t1 + 20, F_MEM, 8'd0, 8'd0);
    push("cold2_mem_gap", t1 + 23, F_MEM, 8'd0, 8'd0);
    push("cold2_core", t1 + 24, F_CORE, 8'd0, 8'd0);

    // 5. Lock loss while in REL_CORE: group re-assert, not counted
    wait_to(t1 + 24);
    pll_locked = 1'b0;
    push("rcore_pending", t1 + 26, F_CORE, 8'd0, 8'd0);
    push("rcore_loss", t1 + 27, F_HOLD, 8'd0, 8'd0);
    push("rcore_wait", t1 + 29, F_HOLD, 8'd0, 8'd0);

    // 2. Relock with a one-cycle glitch after 5 high cycles in FILTER
    wait_to(t1 + 30);
    R = cyc;
    pll_locked = 1'b1;
    push("glitch_norel", R + 11, F_HOLD, 8'd0, 8'd0);
    push("glitch_filter", R + 17, F_HOLD, 8'd0, 8'd0);
    push("glitch_mem", R + 18, F_MEM, 8'd0, 8'd0);
    push("glitch_core", R + 22, F_CORE, 8'd0, 8'd0);
    push("glitch_core_gp", R + 25, F_CORE, 8'd0, 8'd0);
    push("glitch_run", R + 26, F_RUN, 8'd0, 8'd0);
    wait_to(R + 6);
    pll_locked = 1'b0;
    wait_to(R + 7);
    pll_locked = 1'b1;

    // Drop in FILTER on the completing cycle, then relock timeouts (3),
    // then lock arriving on the timeout cycle.
    wait_to(R + 30);
    S = cyc;
    pll_locked = 1'b0;
    push("loss2_pending", S + 2, F_RUN, 8'd0, 8'd0);
    push("loss2_all_rst", S + 3, F_HOLD, 8'd1, 8'd0);
    push("fdrop_wins", S + 21, F_HOLD, 8'd1, 8'd0);
    push("fdrop_wait", S + 22, F_HOLD, 8'd1, 8'd0);
    push("tmo1_before", S + 84, F_HOLD, 8'd1, 8'd0);
    push("tmo1_pll_hi", S + 85, F_RESET, 8'd1, 8'd1);
    push("tmo1_pll_held", S + 88, F_RESET, 8'd1, 8'd1);
    push("tmo1_pll_lo", S + 89, F_HOLD, 8'd1, 8'd1);
    push("tmo2", S + 153, F_RESET, 8'd1, 8'd2);
    push("tmo3", S + 221, F_RESET, 8'd1, 8'd3);
    push("tmo3_pll_lo", S + 225, F_HOLD, 8'd1, 8'd3);
    push("lock_wins", S + 289, F_HOLD, 8'd1, 8'd3);
    push("lock_wins_nopl", S + 290, F_HOLD, 8'd1, 8'd3);
    push("lw_filter", S + 296, F_HOLD, 8'd1, 8'd3);
    push("lw_mem", S + 297, F_MEM, 8'd1, 8'd3);
    wait_to(S + 10);
    pll_locked = 1'b1;
    wait_to(S + 18);
    pll_locked = 1'b0;
    wait_to(S + 286);
    pll_locked = 1'b1;

    // 3. Retry saturation: hold lock low until retry_count pins at 255
    wait_to(S + 300);
    pll_locked = 1'b0;
    W    = S + 303;
    k252 = W + 64 + 68 * 251;
    k253 = W + 64 + 68 * 252;
    push("sat_pre_loss", S + 302, F_CORE, 8'd1, 8'd3);
    push("sat_loss", W, F_HOLD, 8'd1, 8'd3);
    push("sat_tmo4", W + 64, F_RESET, 8'd1, 8'd4);
    push("sat_tmo5", W + 132, F_RESET, 8'd1, 8'd5);
    push("sat_pre_255", k252 - 1, F_HOLD, 8'd1, 8'd254);
    push("sat_255", k252, F_RESET, 8'd1, 8'd255);
    push("sat_pre_stick", k253 - 1, F_HOLD, 8'd1, 8'd255);
    push("sat_stick", k253, F_RESET, 8'd1, 8'd255);

    wait_to(k253 + 2);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL leftover: %0d expectations unchecked, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
